sample_capture: RTL and testbench

//  Receive end of the sample stream (strobe + data) from the sine/DDS generators and FIR outputs.
//  On arm, stores CAP_DEPTH consecutive valid samples into on-chip RAM.

---
 rtl/sample_capture_pkg.sv | 23 ++
 rtl/single_port_ram.sv | 21 ++
 rtl/sample_capture.sv | 192 +++++++++++++++++++
 tb/tb_sample_capture.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_capture_pkg.sv
// Shared types and the trigger comparator for the sample capture block.
// The trigger helper is only referenced when SAMP_CAPTURE_TRIG_EN is defined.
package sample_capture_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE      = 2'd0,
    CAP_WAIT_TRIG = 2'd1,
    CAP_CAPTURE   = 2'd2,
    CAP_READOUT   = 2'd3
  } cap_state_e;

  // Operands are sign-extended to this width by the caller, so any SAMP_WIDTH up to 64 works.
  localparam int TRIG_W = 64;

  function automatic logic trig_cross(
    input logic signed [TRIG_W-1:0] prev,
    input logic signed [TRIG_W-1:0] cur,
    input logic signed [TRIG_W-1:0] lvl
  );
    return (prev < lvl) && (cur >= lvl);
  endfunction

endpackage

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM: one write or one read per cycle, registered read data.
// Contents are not reset; read data reflects the addressed word one cycle later.
module single_port_ram #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/sample_capture.sv
// Captures CAP_DEPTH consecutive valid samples after an arm pulse, then streams them out over ready/valid.
// Define SAMP_CAPTURE_TRIG_EN to wait for a rising crossing of i_trig_level before capturing.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int SAMP_WIDTH = 24,
  parameter int CAP_DEPTH  = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_arm,
  input  logic                  i_samp_valid,
  input  logic [SAMP_WIDTH-1:0] i_samp_data,
  input  logic [SAMP_WIDTH-1:0] i_trig_level,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_valid,
  output logic [SAMP_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  input  logic                  i_rd_ready
);

  localparam int CAP_ADDR = $clog2(CAP_DEPTH);
  localparam int CNT_W    = CAP_ADDR + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CAP_DEPTH - 1);
  localparam logic [CNT_W-1:0] END_IDX  = CNT_W'(CAP_DEPTH);

  // Readout handshake: a word moves when o_rd_valid & i_rd_ready; while o_rd_valid is high
  // and not yet accepted, o_rd_data and o_rd_last hold their values.

  cap_state_e state_q, state_d;
  logic [CNT_W-1:0]    wr_cnt_q, rd_cnt_q;
  logic                ram_we;
  logic [CAP_ADDR-1:0] ram_addr;
  logic [SAMP_WIDTH-1:0] ram_rdata;
  logic                rd_issue, rd_pop, trig_hit;
  logic                inflight_q, inflight_last_q;
  logic [1:0]          skid_cnt_q, occ_next;
  logic [SAMP_WIDTH-1:0] buf0_data_q, buf1_data_q;
  logic                buf0_last_q, buf1_last_q;

`ifdef SAMP_CAPTURE_TRIG_EN
  logic [SAMP_WIDTH-1:0] prev_q;
  logic                  prev_vld_q;

  assign trig_hit = (state_q == CAP_WAIT_TRIG) && i_samp_valid && prev_vld_q &&
                    trig_cross(TRIG_W'($signed(prev_q)), TRIG_W'($signed(i_samp_data)),
                               TRIG_W'($signed(i_trig_level)));

  // The first valid sample after arm only primes prev_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (state_q == CAP_IDLE) begin
      prev_vld_q <= 1'b0;
    end else if (state_q == CAP_WAIT_TRIG && i_samp_valid) begin
      prev_q     <= i_samp_data;
      prev_vld_q <= 1'b1;
    end
  end
`else
  logic unused_trig_level;
  assign unused_trig_level = ^i_trig_level;
  assign trig_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= CAP_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAP_IDLE: if (i_arm) begin
`ifdef SAMP_CAPTURE_TRIG_EN
        state_d = CAP_WAIT_TRIG;
`else
        state_d = CAP_CAPTURE;
`endif
      end
      CAP_WAIT_TRIG: if (trig_hit) state_d = CAP_CAPTURE;
      CAP_CAPTURE:   if (i_samp_valid && wr_cnt_q == LAST_IDX) state_d = CAP_READOUT;
      CAP_READOUT:   if (rd_pop && o_rd_last) state_d = CAP_IDLE;
      default:       state_d = CAP_IDLE;
    endcase
  end

  // Occupancy the skid buffer will reach once the in-flight RAM read lands.
  assign occ_next = skid_cnt_q + {1'b0, inflight_q} - {1'b0, rd_pop};

  always_comb begin
    o_busy   = 1'b0;
    o_done   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = wr_cnt_q[CAP_ADDR-1:0];
    rd_issue = 1'b0;
    case (state_q)
      CAP_WAIT_TRIG: begin
        o_busy   = 1'b1;
        ram_we   = trig_hit;
        ram_addr = '0;
      end
      CAP_CAPTURE: begin
        o_busy = 1'b1;
        ram_we = i_samp_valid;
      end
      CAP_READOUT: begin
        o_done   = 1'b1;
        ram_addr = rd_cnt_q[CAP_ADDR-1:0];
        rd_issue = (rd_cnt_q != END_IDX) && (occ_next < 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (state_q == CAP_IDLE)                        wr_cnt_q <= '0;
      else if (trig_hit)                              wr_cnt_q <= CNT_W'(1);
      else if (state_q == CAP_CAPTURE && i_samp_valid) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (state_q != CAP_READOUT) rd_cnt_q <= '0;
      else if (rd_issue)          rd_cnt_q <= rd_cnt_q + 1'b1;
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && (rd_cnt_q == LAST_IDX);
    end
  end

  single_port_ram #(
    .DATA_WIDTH (SAMP_WIDTH),
    .ADDR_WIDTH (CAP_ADDR)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_addr  (ram_addr),
    .i_wdata (i_samp_data),
    .o_rdata (ram_rdata)
  );

  assign o_rd_valid = (skid_cnt_q != 2'd0);
  assign o_rd_data  = buf0_data_q;
  assign o_rd_last  = o_rd_valid & buf0_last_q;
  assign rd_pop     = o_rd_valid & i_rd_ready;

  // buf0 is the presented head, buf1 the overflow slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_cnt_q  <= 2'd0;
      buf0_data_q <= '0;
      buf1_data_q <= '0;
      buf0_last_q <= 1'b0;
      buf1_last_q <= 1'b0;
    end else begin
      case ({inflight_q, rd_pop})
        2'b11: begin
          if (skid_cnt_q == 2'd2) begin
            buf0_data_q <= buf1_data_q;
            buf0_last_q <= buf1_last_q;
            buf1_data_q <= ram_rdata;
            buf1_last_q <= inflight_last_q;
          end else begin
            buf0_data_q <= ram_rdata;
            buf0_last_q <= inflight_last_q;
          end
        end
        2'b10: begin
          if (skid_cnt_q == 2'd0) begin
            buf0_data_q <= ram_rdata;
            buf0_last_q <= inflight_last_q;
          end else begin
            buf1_data_q <= ram_rdata;
            buf1_last_q <= inflight_last_q;
          end
          skid_cnt_q <= skid_cnt_q + 2'd1;
        end
        2'b01: begin
          buf0_data_q <= buf1_data_q;
          buf0_last_q <= buf1_last_q;
          skid_cnt_q  <= skid_cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// Scoreboard bench for sample_capture (CAP_DEPTH=8); trigger scenarios run when SAMP_CAPTURE_TRIG_EN is defined.
// Expected capture windows come from a list-level model of which samples follow arm (or the crossing).
module tb_sample_capture;

  localparam int W     = 24;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_arm = 1'b0;
  logic         i_samp_valid = 1'b0;
  logic [W-1:0] i_samp_data = '0;
  logic [W-1:0] i_trig_level = '0;
  logic         i_rd_ready = 1'b0;
  logic         o_busy, o_done, o_rd_valid, o_rd_last;
  logic [W-1:0] o_rd_data;

  sample_capture #(.SAMP_WIDTH(W), .CAP_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_arm        (i_arm),
    .i_samp_valid (i_samp_valid),
    .i_samp_data  (i_samp_data),
    .i_trig_level (i_trig_level),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .o_rd_last    (o_rd_last),
    .i_rd_ready   (i_rd_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W:0]   exp_q[$];   // {last, data}
  logic [W-1:0] stim_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit rdy_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: which driven samples make up the capture window.
  function automatic void build_expected();
    int start = 0;
`ifdef SAMP_CAPTURE_TRIG_EN
    start = -1;
    for (int i = 1; i < stim_q.size(); i++) begin
      if ($signed(stim_q[i-1]) < $signed(i_trig_level) && $signed(stim_q[i]) >= $signed(i_trig_level)) begin
        start = i;
        break;
      end
    end
`endif
    for (int k = 0; k < DEPTH; k++) exp_q.push_back({k == DEPTH - 1, stim_q[start + k]});
  endfunction

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_rd_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic do_arm();
    i_arm = 1'b1;
    @(posedge clk); #1;
    i_arm = 1'b0;
  endtask

  // gap_mode < 0: random idle cycles between strobes; otherwise fixed idle count.
  task automatic drive_stim(input int gap_mode);
    foreach (stim_q[i]) begin
      int g = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
      repeat (g) begin @(posedge clk); #1; end
      i_samp_valid = 1'b1;
      i_samp_data  = stim_q[i];
      @(posedge clk); #1;
      i_samp_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || o_done || o_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n >= budget), 64'(0));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic load_ints(input int vals[], input int cnt);
    stim_q.delete();
    for (int i = 0; i < cnt; i++) stim_q.push_back(W'(vals[i]));
  endtask

  // ---------------- monitor ----------------
  int cyc = 0, done_rise_cyc = 0, first_xfer_cyc = 0, last_xfer_cyc = 0, xfer_in_cap = 0;
  bit prev_done = 1'b0, first_pending = 1'b0, chk_done_fall = 1'b0, hold_valid = 1'b0;
  logic [W:0] hold_word = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0; first_pending = 1'b0; chk_done_fall = 1'b0;
      hold_valid = 1'b0; xfer_in_cap = 0;
    end else begin
      cyc++;
      if (o_done && !prev_done) begin
        done_rise_cyc = cyc;
        first_pending = 1'b1;
      end
      prev_done = o_done;
      if (chk_done_fall) begin
        check("done_falls_after_last", 64'(o_done), 64'(0));
        chk_done_fall = 1'b0;
      end
      if (hold_valid) check("stall_hold", {31'b0, o_rd_valid, o_rd_last, o_rd_data}, {31'b0, 1'b1, hold_word});
      hold_valid = o_rd_valid && !i_rd_ready;
      hold_word  = {o_rd_last, o_rd_data};
      if (o_rd_valid) begin
        check("done_in_readout", 64'({o_done, o_busy}), 64'(2'b10));
        if (first_pending) begin
          check("first_valid_latency", 64'(cyc - done_rise_cyc), 64'(2));
          first_pending = 1'b0;
        end
      end
      if (o_rd_valid && i_rd_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_xfer: got 0x%0h with no expected sample at %0t", o_rd_data, $time);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("rd_word", 64'({o_rd_last, o_rd_data}), 64'(e));
          if (xfer_in_cap == 0) first_xfer_cyc = cyc;
          xfer_in_cap++;
          if (e[W]) begin
            last_xfer_cyc = cyc;
            xfer_in_cap   = 0;
            chk_done_fall = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  64'(o_busy), 64'(0));
    check("rst_done",  64'(o_done), 64'(0));
    check("rst_valid", 64'(o_rd_valid), 64'(0));
    check("rst_last",  64'(o_rd_last), 64'(0));
    check("rst_data",  64'(o_rd_data), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

`ifndef SAMP_CAPTURE_TRIG_EN
    // back-to-back samples, ready held high
    rdy_rand = 1'b0;
    stim_q.delete();
    for (int i = 1; i <= 10; i++) stim_q.push_back(W'(i));
    build_expected();
    do_arm();
    drive_stim(0);
    wait_idle(200);
    check("consecutive_reads", 64'(last_xfer_cyc - first_xfer_cyc), 64'(DEPTH - 1));

    // every 3rd cycle, random ready
    rdy_rand = 1'b1;
    stim_q.delete();
    for (int i = 100; i <= 107; i++) stim_q.push_back(W'(i));
    build_expected();
    do_arm();
    drive_stim(2);
    wait_idle(300);

    // random data, random gaps, random ready
    for (int r = 0; r < 3; r++) begin
      stim_q.delete();
      for (int i = 0; i < 12; i++) stim_q.push_back(W'($urandom));
      build_expected();
      do_arm();
      drive_stim(-1);
      wait_idle(400);
    end
`else
    rdy_rand = 1'b1;
    i_trig_level = '0;
    load_ints('{-5, -3, 2, 7, -1, 4, 10, 11, 12, 13, 14}, 11);
    build_expected();
    do_arm();
    drive_stim(0);
    wait_idle(300);

    load_ints('{5, -4, 1, 2, 3, 4, 5, 6, 7, 8, 9}, 11);
    build_expected();
    do_arm();
    drive_stim(1);
    wait_idle(300);

    for (int r = 0; r < 3; r++) begin
      int lvl = int'($urandom_range(0, 20)) - 10;
      i_trig_level = W'(lvl);
      stim_q.delete();
      for (int i = 0; i < 15; i++) stim_q.push_back(W'(int'($urandom_range(0, 100)) - 50));
      stim_q.push_back(W'(lvl - 1));
      stim_q.push_back(W'(lvl));
      for (int i = 0; i < 9; i++) stim_q.push_back(W'(int'($urandom_range(0, 100)) - 50));
      build_expected();
      do_arm();
      drive_stim(-1);
      wait_idle(500);
    end
    i_trig_level = '0;
`endif

    // reset in the middle of a capture: no readout may follow
    rdy_rand = 1'b0;
`ifdef SAMP_CAPTURE_TRIG_EN
    load_ints('{-1, 1, 2, 3, 4}, 5);
`else
    load_ints('{1, 2, 3, 4}, 4);
`endif
    do_arm();
    drive_stim(0);
    check("busy_before_abort", 64'(o_busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy",  64'(o_busy), 64'(0));
    check("abort_done",  64'(o_done), 64'(0));
    check("abort_valid", 64'(o_rd_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_after_abort", 64'({o_busy, o_done}), 64'(0));

    // arm pulses during capture and readout are ignored
    rdy_rand = 1'b1;
    load_ints('{-1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, 11);
    build_expected();
    do_arm();
    fork
      drive_stim(0);
      begin
        repeat (4) @(posedge clk);
        #1;
        do_arm();
      end
    join
    begin
      int n = 0;
      while (!o_done && n < 100) begin @(posedge clk); #1; n++; end
      check("reach_readout", 64'(o_done), 64'(1));
    end
    do_arm();
    wait_idle(300);
    repeat (10) @(posedge clk);
    #1;
    check("no_rearm", 64'({o_busy, o_done, o_rd_valid}), 64'(0));
    check("exp_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
